// File: rtl/ext_memory_interface.sv
// Program-memory responder and optional 4-bit I/O port on the multiplexed CPU bus.
// Define IO_PORT_EN to include the SRC/WRR/RDR I/O port logic.
//
// state   | meaning
// A1..A3  | address nibbles low, mid, high (A3 issues the memory read)
// M1, M2  | opcode nibbles driven onto the bus (opr, then opa)
// X1..X3  | execute phases; X2 carries SRC chip number / WRR data / RDR drive
// IDLE    | no bus cycle in progress; waits for sync
module ext_memory_interface #(
    parameter logic [3:0] CHIP_ID    = 4'h0,
    parameter logic [3:0] PORT_RESET = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sync,
    input  logic        cm_rom,
    input  logic [3:0]  data_in,
    output logic [3:0]  data_out,
    output logic        data_out_en,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic [3:0]  port_in,
    output logic [3:0]  port_out
);

    typedef enum logic [3:0] {
        PH_A1   = 4'd0,
        PH_A2   = 4'd1,
        PH_A3   = 4'd2,
        PH_M1   = 4'd3,
        PH_M2   = 4'd4,
        PH_X1   = 4'd5,
        PH_X2   = 4'd6,
        PH_X3   = 4'd7,
        PH_IDLE = 4'd8
    } phase_t;

    phase_t      phase;
    logic [7:0]  addr_lo;
    logic [11:0] mem_addr_q;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        rdr_drive;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase      <= PH_IDLE;
            addr_lo    <= 8'h00;
            mem_addr_q <= 12'h000;
            opr        <= 4'h0;
            opa        <= 4'h0;
        end else begin
            case (phase)
                PH_A1:   addr_lo[3:0] <= data_in;
                PH_A2:   addr_lo[7:4] <= data_in;
                PH_A3:   mem_addr_q   <= {data_in, addr_lo};
                PH_M1:   {opr, opa}   <= mem_rdata;
                default: ;
            endcase
            // sync always restarts the cycle, even mid-instruction
            if (sync)
                phase <= PH_A1;
            else if (phase == PH_X3 || phase == PH_IDLE)
                phase <= PH_IDLE;
            else
                phase <= phase_t'(phase + 4'd1);
        end
    end

`ifdef IO_PORT_EN
    logic       selected;
    logic       io_pend;
    logic [3:0] io_op;
    logic [3:0] port_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            selected <= 1'b0;
            io_pend  <= 1'b0;
            io_op    <= 4'h0;
            port_q   <= PORT_RESET;
        end else begin
            if (phase == PH_X2 && opr == 4'h2 && opa[0] && cm_rom)
                selected <= (data_in == CHIP_ID);
            if (phase == PH_M2 && opr == 4'hE && cm_rom && selected) begin
                io_pend <= 1'b1;
                io_op   <= opa;
            end else if (phase == PH_X2) begin
                io_pend <= 1'b0;
            end
            if (phase == PH_X2 && io_pend && io_op == 4'h2)
                port_q <= data_in;
            // a restarted cycle never completes its pending I/O action
            if (sync)
                io_pend <= 1'b0;
        end
    end

    assign rdr_drive = (phase == PH_X2) && io_pend && (io_op == 4'hA);
    assign port_out  = port_q;
`else
    logic unused_io;
    assign unused_io = cm_rom ^ (^opr);
    assign rdr_drive = 1'b0;
    assign port_out  = PORT_RESET;
`endif

    always_comb begin
        data_out    = 4'h0;
        data_out_en = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = mem_addr_q;
        case (phase)
            PH_A3: begin
                mem_rd   = 1'b1;
                mem_addr = {data_in, addr_lo};
            end
            PH_M1: begin
                data_out_en = 1'b1;
                data_out    = mem_rdata[7:4];
            end
            PH_M2: begin
                data_out_en = 1'b1;
                data_out    = opa;
            end
            PH_X2: begin
                if (rdr_drive) begin
                    data_out_en = 1'b1;
                    data_out    = port_in;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ext_memory_interface.sv
// Bench for ext_memory_interface: instruction-level model of fetch and I/O port,
// checked against the DUT bus outputs every cycle.
module tb_ext_memory_interface;

    localparam logic [3:0] CHIP_ID    = 4'h3;
    localparam logic [3:0] PORT_RESET = 4'h5;
`ifdef IO_PORT_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, sync, cm_rom;
    logic [3:0]  data_in, data_out, port_in, port_out;
    logic        data_out_en, mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [4096];

    int checks = 0;
    int errors = 0;

    bit          chk_on = 1'b0;
    bit          exp_en, exp_rd, exp_addr_on;
    logic [3:0]  exp_data, exp_port;
    logic [11:0] exp_addr;

    bit          sel_model;
    logic [3:0]  port_model;

    ext_memory_interface #(.CHIP_ID(CHIP_ID), .PORT_RESET(PORT_RESET)) dut (
        .clock(clock), .reset(reset), .sync(sync), .cm_rom(cm_rom),
        .data_in(data_in), .data_out(data_out), .data_out_en(data_out_en),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .port_in(port_in), .port_out(port_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("data_out_en", 12'(data_out_en), 12'(exp_en));
            chk("data_out", 12'(data_out), 12'(exp_data));
            chk("mem_rd", 12'(mem_rd), 12'(exp_rd));
            chk("port_out", 12'(port_out), 12'(exp_port));
            if (exp_addr_on) chk("mem_addr", mem_addr, exp_addr);
        end
    end

    task automatic step(input bit s, input bit c, input logic [3:0] d, input bit r,
                        input bit een, input logic [3:0] edata, input bit erd,
                        input bit eaon, input logic [11:0] eaddr);
        @(posedge clock);
        #1;
        sync = s; cm_rom = c; data_in = d; reset = r;
        exp_en = een; exp_data = edata; exp_rd = erd;
        exp_addr_on = eaon; exp_addr = eaddr; exp_port = port_model;
        chk_on = 1'b1;
    endtask

    // One complete instruction cycle: sync cycle followed by A1..X3.
    task automatic fetch(input logic [11:0] a, input bit cm_m2, input bit cm_x2,
                         input logic [3:0] x2d);
        logic [7:0] b;
        bit src, io, rdr, wrr;
        b   = mem[a];
        src = IO_EN && b[7:4] == 4'h2 && b[0] && cm_x2;
        io  = IO_EN && b[7:4] == 4'hE && cm_m2 && sel_model;
        rdr = io && b[3:0] == 4'hA;
        wrr = io && b[3:0] == 4'h2;
        step(1, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, a[3:0], 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, a[7:4], 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, a[11:8], 0, 0, 4'h0, 1,  1, a);
        step(0, 0, 4'h0, 0,  1, b[7:4], 0,  0, 12'h0);
        step(0, cm_m2, 4'h0, 0, 1, b[3:0], 0, 0, 12'h0);
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, cm_x2, x2d, 0, rdr, rdr ? port_in : 4'h0, 0, 0, 12'h0);
        if (src) sel_model = (x2d == CHIP_ID);
        if (wrr) port_model = x2d;
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem_rdata  = 8'h00;
        reset = 1'b1; sync = 1'b0; cm_rom = 1'b0; data_in = 4'h0; port_in = 4'h0;
        sel_model  = 1'b0;
        port_model = PORT_RESET;
        @(posedge clock);

        // reset, then idle with no sync and noise on the bus
        step(0, 0, 4'h0, 1,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  1, 12'h000);
        step(0, 1, 4'hF, 0,  0, 4'h0, 0,  1, 12'h000);

        // literal fetch of 0xD7 from 0x3A5
        mem[12'h3A5] = 8'hD7;
        step(1, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h5, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'hA, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h3, 0,  0, 4'h0, 1,  1, 12'h3A5);
        step(0, 0, 4'h0, 0,  1, 4'hD, 0,  0, 12'h0);
        step(0, 0, 4'h0, 0,  1, 4'h7, 0,  1, 12'h3A5);
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);

        // SRC to this chip, then WRR 0x9
        mem[12'h010] = 8'h21;
        mem[12'h011] = 8'hE2;
        mem[12'h013] = 8'hEA;
        mem[12'h014] = 8'hE5;
        fetch(12'h010, 0, 1, CHIP_ID);
        fetch(12'h011, 1, 0, 4'h9);
        @(negedge clock);
        chk("wrr_port_literal", 12'(port_out), 12'(IO_EN ? 4'h9 : PORT_RESET));

        // RDR with port_in = 6, non-I/O E opcode, then deselect
        port_in = 4'h6;
        fetch(12'h010, 0, 1, CHIP_ID);
        fetch(12'h013, 1, 0, 4'h0);
        fetch(12'h014, 1, 0, 4'hB);
        fetch(12'h010, 0, 1, 4'(CHIP_ID + 4'h1));
        fetch(12'h013, 1, 0, 4'h0);
        fetch(12'h011, 1, 0, 4'h1);
        port_in = 4'hC;
        fetch(12'h010, 0, 1, CHIP_ID);
        fetch(12'h013, 1, 0, 4'h0);
        fetch(12'h011, 1, 0, 4'hA);

        // sync at M1 restarts, reset at M2 clears everything
        mem[12'h120] = 8'h4B;
        mem[12'h234] = 8'h96;
        step(1, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h2, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h1, 0,  0, 4'h0, 1,  1, 12'h120);
        step(1, 0, 4'h0, 0,  1, 4'h4, 0,  0, 12'h0);
        step(0, 0, 4'h4, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h3, 0,  0, 4'h0, 0,  0, 12'h0);
        step(0, 0, 4'h2, 0,  0, 4'h0, 1,  1, 12'h234);
        step(0, 0, 4'h0, 0,  1, 4'h9, 0,  0, 12'h0);
        step(0, 1, 4'h0, 1,  1, 4'h6, 0,  0, 12'h0);
        port_model = PORT_RESET;
        sel_model  = 1'b0;
        step(0, 0, 4'h0, 0,  0, 4'h0, 0,  1, 12'h000);
        fetch(12'h011, 1, 0, 4'hF);

        // address wrap
        mem[12'hFFF] = 8'h3C;
        mem[12'h000] = 8'hA1;
        fetch(12'hFFF, 0, 0, 4'h0);
        fetch(12'h000, 0, 0, 4'h0);

        @(posedge clock);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
